// File: rtl/parking_pkg.sv
// Shared constants and error encoding for the parking slot manager.
package parking_pkg;

    localparam int DEF_NUM_SLOTS = 3;
    localparam int DEF_TIME_W    = 10;
    localparam int DEF_COST_W    = 10;
    localparam int DEF_RATE      = 1;

    // Reason for the most recent rejected request.
    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_BAD_SEL    = 2'd1,
        ERR_SLOT_BUSY  = 2'd2,
        ERR_SLOT_EMPTY = 2'd3
    } err_code_e;

endpackage

// File: rtl/parking_edge_det.sv
// Rising-edge detector for a request level. The output pulse is
// combinational in the cycle the level first reads high, so the consumer
// registers the event's effects on that same clock edge. A level that is
// already high when reset releases is ignored until it has been seen low.
module parking_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev_q;
    logic armed_q;

    // History of the level, plus an arm flag that sets once the level is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= level;
            armed_q <= armed_q | ~level;
        end
    end

    assign pulse = level & ~prev_q & armed_q;

endmodule

// File: rtl/parking_slot_manager.sv
// Parking slot manager: tracks occupancy of NUM_SLOTS slots, stamps entry
// times, computes the exit cost from the wrapping time base, and emits
// one-cycle log-write strobes. Rejected requests pulse err and latch a reason.
module parking_slot_manager
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int TIME_W    = DEF_TIME_W,
    parameter int COST_W    = DEF_COST_W,
    parameter int RATE      = DEF_RATE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             car_enter,
    input  logic                             car_exit,
    input  logic [NUM_SLOTS-1:0]             car_sel,
    input  logic [TIME_W-1:0]                timer_count,
    output logic [NUM_SLOTS-1:0]             slot_state,
    output logic [NUM_SLOTS*TIME_W-1:0]      slot_enter_time,
    output logic [NUM_SLOTS*COST_W-1:0]      slot_cost,
    output logic [COST_W-1:0]                current_cost,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   occupancy,
    output logic                             full,
    output logic                             write_entry,
    output logic                             write_cost,
    output logic [$clog2(NUM_SLOTS)-1:0]     wr_slot,
    output logic [TIME_W-1:0]                entry_time_in,
    output logic [COST_W-1:0]                cost_in,
    output logic                             err,
    output logic [1:0]                       err_code
);

    localparam int OCC_W  = $clog2(NUM_SLOTS + 1);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int PROD_W = TIME_W + 32;

    // Elapsed ticks times RATE, clamped to the largest representable cost.
    function automatic logic [COST_W-1:0] sat_cost(input logic [TIME_W-1:0] dt);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(dt) * PROD_W'(RATE);
        if ((prod >> COST_W) != '0)
            sat_cost = '1;
        else
            sat_cost = prod[COST_W-1:0];
    endfunction

    logic              enter_ev;
    logic              exit_ev;
    logic [OCC_W-1:0]  sel_cnt;
    logic              sel_onehot;
    logic [SLOT_W-1:0] sel_idx;
    logic [TIME_W-1:0] entry_old;
    logic              slot_busy;
    logic [COST_W-1:0] exit_cost;
    logic              do_enter;
    logic              do_exit;
    logic              reject;
    err_code_e         rej_code;

    parking_edge_det u_enter_edge (
        .clk   (clk),
        .reset (reset),
        .level (car_enter),
        .pulse (enter_ev)
    );

    parking_edge_det u_exit_edge (
        .clk   (clk),
        .reset (reset),
        .level (car_exit),
        .pulse (exit_ev)
    );

    assign full = (occupancy == OCC_W'(NUM_SLOTS));

    // Decode the select, look up the selected slot, and classify the event.
    always_comb begin
        sel_cnt   = '0;
        sel_idx   = '0;
        entry_old = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (car_sel[i]) begin
                sel_cnt   = sel_cnt + OCC_W'(1);
                sel_idx   = SLOT_W'(i);
                entry_old = slot_enter_time[i*TIME_W +: TIME_W];
            end
        end
        sel_onehot = (sel_cnt == OCC_W'(1));
        slot_busy  = |(slot_state & car_sel);
        exit_cost  = sat_cost(timer_count - entry_old);

        do_enter = 1'b0;
        do_exit  = 1'b0;
        reject   = 1'b0;
        rej_code = ERR_NONE;
        if (enter_ev && exit_ev) begin
            reject   = 1'b1;
            rej_code = ERR_BAD_SEL;
        end else if (enter_ev) begin
            if (!sel_onehot) begin
                reject   = 1'b1;
                rej_code = ERR_BAD_SEL;
            end else if (slot_busy || full) begin
                reject   = 1'b1;
                rej_code = ERR_SLOT_BUSY;
            end else begin
                do_enter = 1'b1;
            end
        end else if (exit_ev) begin
            if (!sel_onehot) begin
                reject   = 1'b1;
                rej_code = ERR_BAD_SEL;
            end else if (!slot_busy) begin
                reject   = 1'b1;
                rej_code = ERR_SLOT_EMPTY;
            end else begin
                do_exit = 1'b1;
            end
        end
    end

    // Slot table, cost outputs and strobes, all updated on the sampling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_state      <= '0;
            slot_enter_time <= '0;
            slot_cost       <= '0;
            current_cost    <= '0;
            occupancy       <= '0;
            write_entry     <= 1'b0;
            write_cost      <= 1'b0;
            wr_slot         <= '0;
            entry_time_in   <= '0;
            cost_in         <= '0;
            err             <= 1'b0;
            err_code        <= 2'd0;
        end else begin
            write_entry <= 1'b0;
            write_cost  <= 1'b0;
            err         <= 1'b0;
            if (reject) begin
                err      <= 1'b1;
                err_code <= rej_code;
            end
            if (do_enter) begin
                slot_state <= slot_state | car_sel;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (car_sel[i]) begin
                        slot_enter_time[i*TIME_W +: TIME_W] <= timer_count;
                        slot_cost[i*COST_W +: COST_W]       <= '0;
                    end
                end
                current_cost  <= '0;
                occupancy     <= occupancy + OCC_W'(1);
                write_entry   <= 1'b1;
                wr_slot       <= sel_idx;
                entry_time_in <= timer_count;
                cost_in       <= '0;
            end
            if (do_exit) begin
                slot_state <= slot_state & ~car_sel;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (car_sel[i]) begin
                        slot_enter_time[i*TIME_W +: TIME_W] <= '0;
                        slot_cost[i*COST_W +: COST_W]       <= exit_cost;
                    end
                end
                current_cost <= exit_cost;
                occupancy    <= occupancy - OCC_W'(1);
                write_cost   <= 1'b1;
                wr_slot      <= sel_idx;
                cost_in      <= exit_cost;
            end
        end
    end

endmodule

// File: doc/parking_slot_manager.md
PARKING_SLOT_MANAGER -- requirements
Module: parking_slot_manager

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 3, number of parking slots (2..16).
REQ-002 SHALL have parameter TIME_W, default 10, width of timer and entry-time values.
REQ-003 SHALL have parameter COST_W, default 10, width of cost values.
REQ-004 SHALL have parameter RATE, default 1, cost units charged per timer tick.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports car_enter and car_exit  input  1 each  request levels; only rising edges act.
REQ-008 SHALL have port car_sel  input  NUM_SLOTS  one-hot slot select.
REQ-009 SHALL have port timer_count  input  TIME_W  free-running time base that wraps modulo 2^TIME_W.
REQ-010 SHALL have port slot_state  output  NUM_SLOTS  bit i = 1 while slot i is occupied.
REQ-011 SHALL have port slot_enter_time  output  NUM_SLOTS*TIME_W  slot i's entry time at bits [i*TIME_W +: TIME_W].
REQ-012 SHALL have port slot_cost  output  NUM_SLOTS*COST_W  slot i's last exit cost at bits [i*COST_W +: COST_W].
REQ-013 SHALL have port current_cost  output  COST_W  cost of the most recent exit, for display.
REQ-014 SHALL have port occupancy  output  $clog2(NUM_SLOTS+1)  number of occupied slots.
REQ-015 SHALL have port full  output  1  high when occupancy equals NUM_SLOTS.
REQ-016 SHALL have ports write_entry and write_cost  output  1 each  one-cycle log-write strobes.
REQ-017 SHALL have ports wr_slot  output  $clog2(NUM_SLOTS)  slot index; entry_time_in  output  TIME_W; cost_in  output  COST_W.
REQ-018 SHALL have port err  output  1  one-cycle pulse on a rejected request; err_code  output  2  reason, held until the next err pulse.

Function
REQ-019 SHALL detect an event on the cycle where the request is 1 and was 0 in the previous cycle; a held-high request SHALL act exactly once.
REQ-020 SHALL register all effects of an event on the clock edge that samples it, so strobes and updated outputs appear one cycle after the input rises.
REQ-021 SHALL, on an enter event with a valid one-hot select of a free slot: set slot_state[i], capture timer_count as the entry time, clear slot_cost[i] and current_cost, increment occupancy, and pulse write_entry with wr_slot=i, entry_time_in=timer_count and cost_in=0.
REQ-022 SHALL, on an exit event for an occupied slot: clear slot_state[i], compute cost = ((timer_count - entry) mod 2^TIME_W) * RATE, write it to slot_cost[i], current_cost and cost_in, clear the entry time, decrement occupancy, and pulse write_cost with wr_slot=i.
REQ-023 SHALL saturate cost to 2^COST_W-1 when the product exceeds COST_W bits.
REQ-024 SHALL reject the request, change no slot state, and pulse err with err_code = 1 (BAD_SEL) when car_sel is not one-hot.
REQ-025 SHALL reject an enter to an occupied slot with err_code = 2 (SLOT_BUSY).
REQ-026 SHALL reject an exit from a free slot with err_code = 3 (SLOT_EMPTY).
REQ-027 SHALL treat enter and exit events in the same cycle as BAD_SEL; neither is executed.
REQ-028 SHALL give an enter to a free slot while full=1 the same handling as SLOT_BUSY, since full=1 implies no slot is free.
REQ-029 SHALL hold write_entry, write_cost and err low in every cycle without an accepted or rejected event.

Reset
REQ-030 SHALL, while reset=0, asynchronously drive all outputs, entry times, costs, occupancy, err_code and the edge-detect history registers to 0.
REQ-031 SHALL ignore a request that is high when reset releases until it goes low and rises again.
REQ-032 SHALL abandon any pending event when reset asserts mid-operation; no strobe SHALL appear afterwards.

Structure
REQ-033 SHALL take the err_code encoding (NONE=0, BAD_SEL=1, SLOT_BUSY=2, SLOT_EMPTY=3) and the default parameter constants from shared package parking_pkg.
REQ-034 SHALL instance sub-module parking_edge_det (clk, reset, level in, one-cycle pulse out) once for car_enter and once for car_exit.

Verification
REQ-035 SHALL cover: reset, timer=5, enter sel=001 -> next cycle slot_state=001, entry0=5, write_entry pulse, wr_slot=0, occupancy=1.
REQ-036 SHALL cover: slot0 entered at 5, exit sel=001 at timer=47 -> cost_in=current_cost=slot_cost0=42, write_cost pulse, occupancy=0.
REQ-037 SHALL cover: wrap-around with TIME_W=10, enter at 1020, exit at 4 -> cost 8; with RATE=4, enter at 0, exit at 300 -> cost saturates to 1023.
REQ-038 SHALL cover: fill all 3 slots -> full=1; enter sel=010 -> err pulse, err_code=2, and no state change.
REQ-039 SHALL cover: sel=011 enter -> err_code=1; exit of a free slot -> err_code=3; enter and exit rising together -> err_code=1.
REQ-040 SHALL cover: car_enter held high for 10 cycles -> exactly one write_entry; reset pulsed low mid-hold -> all outputs 0 and no strobe until a new rising edge.
